// File: rtl/bcd_updown_counter_n.sv
//------------------------------------------------------------------------------
// Module      : bcd_updown_counter_n
// Description : Multi-digit BCD up/down counter with prescaled stepping,
//               synchronous clear, clamped parallel load and a one-cycle
//               terminal-count pulse for cascading.
//               Optional macro BCD_CNT_SAT_EN selects saturate mode
//               (default build wraps at the limits).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_updown_counter_n #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  zero
);

    localparam int c_W  = 4 * DIGITS;
    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

    logic [c_W-1:0]  r_count;
    logic            r_tc;
    logic [c_PW-1:0] r_pre_cnt;

    logic            w_step;
    logic [c_W-1:0]  w_next;
    logic            w_terminal;
    logic [c_W-1:0]  w_load_clamped;

    // A step fires on the last enabled clock of each prescale interval.
    assign w_step = en && (r_pre_cnt == c_PRE_LAST);

    // Any load digit outside 0..9 is forced to 9 so count stays pure BCD.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
            assign w_load_clamped[4*gi +: 4] =
                (load_value[4*gi +: 4] > 4'd9) ? 4'd9 : load_value[4*gi +: 4];
        end
    endgenerate

    // Full ripple of carry (up) or borrow (down) through all digits; a carry
    // surviving past the top digit means every digit was at its limit.
    always_comb begin
        w_next     = r_count;
        w_terminal = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_terminal) begin
                if (up_down) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_terminal       = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_next[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_terminal       = 1'b0;
                    end
                end
            end
        end
    end

    // Count, prescaler and tc state: reset > clear > load > step > hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_tc      <= 1'b0;
            r_pre_cnt <= '0;
        end else if (clear) begin
            r_count   <= '0;
            r_tc      <= 1'b0;
            r_pre_cnt <= '0;
        end else if (load) begin
            r_count   <= w_load_clamped;
            r_tc      <= 1'b0;
            r_pre_cnt <= '0;
        end else begin
            r_tc <= 1'b0;
            if (w_step) begin
                r_pre_cnt <= '0;
`ifdef BCD_CNT_SAT_EN
                // At the limit the count holds and only tc reports the attempt.
                if (w_terminal) begin
                    r_tc <= 1'b1;
                end else begin
                    r_count <= w_next;
                end
`else
                r_count <= w_next;
                r_tc    <= w_terminal;
`endif
            end else if (en) begin
                r_pre_cnt <= r_pre_cnt + c_PW'(1);
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter_n.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_updown_counter_n
// Description : Directed bench for bcd_updown_counter_n, DIGITS=2, with one
//               instance at PRESCALE=1 (a_*) and one at PRESCALE=3 (b_*).
//               Expected values follow BCD_CNT_SAT_EN when it is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_updown_counter_n;

    logic       clk = 1'b0;

    logic       a_rst_n, a_en, a_up, a_clear, a_load;
    logic [7:0] a_lv, a_count;
    logic       a_tc, a_zero;

    logic       b_rst_n, b_en, b_up, b_clear, b_load;
    logic [7:0] b_lv, b_count;
    logic       b_tc, b_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.DIGITS(2), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset_n(a_rst_n), .en(a_en), .up_down(a_up),
        .clear(a_clear), .load(a_load), .load_value(a_lv),
        .count(a_count), .tc(a_tc), .zero(a_zero)
    );

    bcd_updown_counter_n #(.DIGITS(2), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset_n(b_rst_n), .en(b_en), .up_down(b_up),
        .clear(b_clear), .load(b_load), .load_value(b_lv),
        .count(b_count), .tc(b_tc), .zero(b_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_en = 1'b1; a_up = 1'b1; a_clear = 1'b0;
        a_load  = 1'b1; a_lv = 8'h55;
        b_rst_n = 1'b0; b_en = 1'b0; b_up = 1'b1; b_clear = 1'b0;
        b_load  = 1'b0; b_lv = 8'h00;

        // Reset held for two clocks while en and load are high.
        tick(); tick();
        check("rst_count", a_count, 8'h00);
        check("rst_tc",    a_tc,    1'b0);
        check("rst_zero",  a_zero,  1'b1);
        a_rst_n = 1'b1; a_load = 1'b0;
        tick();
        check("first_step", a_count, 8'h01);
        check("first_zero", a_zero,  1'b0);

        // Up ripple and wrap/saturate from 0x98.
        a_load = 1'b1; a_lv = 8'h98;
        tick();
        check("ld98", a_count, 8'h98);
        a_load = 1'b0;
        tick();
        check("up99",    a_count, 8'h99);
        check("up99_tc", a_tc,    1'b0);
        tick();
`ifdef BCD_CNT_SAT_EN
        check("sat_hi",    a_count, 8'h99);
        check("sat_hi_tc", a_tc,    1'b1);
        tick();
        check("sat_hi2",    a_count, 8'h99);
        check("sat_hi2_tc", a_tc,    1'b1);
`else
        check("wrap00",    a_count, 8'h00);
        check("wrap00_tc", a_tc,    1'b1);
        tick();
        check("wrap01",    a_count, 8'h01);
        check("wrap01_tc", a_tc,    1'b0);
`endif

        // Down borrow from 0x10, walk to 0x00, then wrap/saturate.
        a_load = 1'b1; a_lv = 8'h10; a_up = 1'b0;
        tick();
        check("ld10", a_count, 8'h10);
        a_load = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            tick();
            check("dn_count", a_count, 32'(i));
            check("dn_zero",  a_zero,  (i == 0) ? 1'b1 : 1'b0);
            check("dn_tc",    a_tc,    1'b0);
        end
        tick();
`ifdef BCD_CNT_SAT_EN
        check("sat_lo",    a_count, 8'h00);
        check("sat_lo_tc", a_tc,    1'b1);
`else
        check("wrap99",    a_count, 8'h99);
        check("wrap99_tc", a_tc,    1'b1);
        check("wrap99_z",  a_zero,  1'b0);
`endif

        // Priority and clamping on load.
        a_en = 1'b0;
        a_clear = 1'b1; a_load = 1'b1; a_lv = 8'h42;
        tick();
        check("clr_over_ld", a_count, 8'h00);
        check("clr_tc",      a_tc,    1'b0);
        a_clear = 1'b0; a_lv = 8'hAF;
        tick();
        check("clampAF", a_count, 8'h99);
        a_lv = 8'h3C;
        tick();
        check("clamp3C", a_count, 8'h39);
        a_load = 1'b0;
        tick();
        check("hold_en0", a_count, 8'h39);

        // Prescaler of 3 starting from reset.
        tick();
        b_rst_n = 1'b1; b_en = 1'b1; b_up = 1'b1;
        tick(); check("ps_c1", b_count, 8'h00);
        tick(); check("ps_c2", b_count, 8'h00);
        tick(); check("ps_c3", b_count, 8'h01);
        tick(); check("ps_c4", b_count, 8'h01);
        tick(); check("ps_c5", b_count, 8'h01);
        tick(); check("ps_c6", b_count, 8'h02);
        tick(); // pre_cnt now 1
        b_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ps_gap", b_count, 8'h02);
        end
        b_en = 1'b1;
        tick(); check("ps_c13", b_count, 8'h02);
        tick(); check("ps_c14", b_count, 8'h03);

        // Direction changes between steps are ignored until the step edge.
        b_up = 1'b0;
        tick(); check("dir_ns1", b_count, 8'h03);
        b_up = 1'b1;
        tick(); check("dir_ns2", b_count, 8'h03);
        tick(); check("dir_step", b_count, 8'h04);

        // Mid-run reset at 0x57 restarts the prescaler.
        b_load = 1'b1; b_lv = 8'h57;
        tick(); check("ld57", b_count, 8'h57);
        b_load = 1'b0;
        tick(); check("run57", b_count, 8'h57);
        b_rst_n = 1'b0;
        tick();
        check("mid_rst",    b_count, 8'h00);
        check("mid_rst_tc", b_tc,    1'b0);
        check("mid_rst_z",  b_zero,  1'b1);
        b_rst_n = 1'b1;
        tick(); check("rst_p1", b_count, 8'h00);
        tick(); check("rst_p2", b_count, 8'h00);
        tick(); check("rst_p3", b_count, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
